bitrev_frame_feeder: RTL and testbench
======================================

// Module: bitrev_frame_feeder
// PURPOSE
//   Converts natural-order complex frames of N samples into bit-reversed order.
//   It is the input-side counterpart of the FFT output sorter: it sits in front of
//   the IFFT/FFT core that expects bit-reversed input. Ping-pong buffering sustains
//   one sample per cycle.
//   Valid/ready handshakes on both sides carry back-pressure.
// PARAMETERS
//   N      64  frame length in complex samples; power of two, >= 4
//   LOG2N  6   log2(N); index width
//   WIDTH  32  width of each real/imaginary word
// PORTS
//   clk        in   1      clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      input sample valid
//   in_ready   out  1      block can accept an input sample
//   in_re      in   WIDTH  input real part, natural order
//   in_im      in   WIDTH  input imaginary part, natural order
//   out_valid  out  1      output sample valid
//   out_ready  in   1      downstream accepts the output sample
//   out_re     out  WIDTH  output real part, bit-reversed order
//   out_im     out  WIDTH  output imaginary part, bit-reversed order
//   out_sof    out  1      first sample of an output frame
//   out_eof    out  1      last sample of an output frame
//   out_idx    out  LOG2N  natural index of the current output sample
// BEHAVIOUR
// - Storage: two banks of N x {re,im}. Per-bank full flag full[1:0].
//   Memory contents are not reset.
// - Write side (wr_bank, wr_cnt):
//   - in_ready = !full[wr_bank].
//   - A sample is accepted when in_valid && in_ready. It is stored at
//     bank[wr_bank][wr_cnt], then wr_cnt increments.
//   - Accept with wr_cnt == N-1: set full[wr_bank], toggle wr_bank, wr_cnt <= 0.
//   - in_valid while in_ready = 0 is ignored; upstream holds its data.
//   - Gaps in in_valid are allowed mid-frame; the frame continues from wr_cnt.
// - Read side (rd_bank, rd_cnt):
//   - out_valid = full[rd_bank].
//   - out_idx = bitrev(rd_cnt), i.e. rd_cnt with its LOG2N bits reversed.
//   - out_re/out_im = bank[rd_bank][out_idx], combinational read.
//   - A sample is consumed when out_valid && out_ready: rd_cnt increments.
//   - Consume with rd_cnt == N-1: clear full[rd_bank], toggle rd_bank, rd_cnt <= 0.
//   - out_sof = out_valid && rd_cnt == 0.
//   - out_eof = out_valid && rd_cnt == N-1.
//   - When out_valid = 0: out_re, out_im, out_idx, out_sof and out_eof are all 0.
//   - While out_valid && !out_ready, all outputs hold stable.
// - Latency: out_valid rises the cycle after the N-th sample of a frame is
//   accepted, provided the read bank is free.
//   With continuous in_valid and out_ready = 1, in_ready stays 1 and output is
//   gap-free after the first frame.
// - Simultaneous events:
//   - A set and a clear in the same cycle always address different banks;
//     both take effect.
//   - The same bank cannot be set and cleared in one cycle: setting requires
//     !full, clearing requires full.
// - Full condition: both banks full -> in_ready = 0 until the read side
//   finishes its frame. in_ready returns to 1 the cycle after that final consume.
// - Reset (asserted at any time, including mid-frame):
//   - full = 0, wr_bank = rd_bank = 0, wr_cnt = rd_cnt = 0.
//   - All outputs 0 immediately (asynchronous), except that in_ready = 1 once
//     reset is released.
//   - Partial and pending frames are discarded.
// TESTING
// 1. One frame with re = k, im = 1000+k (k = 0..63), out_ready = 1
//    -> out_valid the cycle after the 64th accept.
//    -> out_re sequence 0, 32, 16, 48, 8, ... 63; out_im = 1000 + out_re.
//    -> out_sof on the first sample, out_eof on the 64th.
// 2. Three back-to-back frames, in_valid always 1, out_ready = 1
//    -> in_ready never falls; 192 gap-free outputs, each frame correctly bit-reversed.
// 3. out_ready = 0, in_valid = 1 continuously
//    -> in_ready falls after exactly 128 accepts.
//    -> Releasing out_ready: 2 frames come out in order; in_ready = 1 one cycle
//       after the 64th consume.
// 4. Random in_valid gaps and out_ready toggling over 20 frames
//    -> Every output matches a golden bitrev model; outputs are stable during stalls.
// 5. reset_n pulsed low after 20 inputs of a frame (with a full frame pending)
//    -> out_valid = 0 and outputs 0 immediately.
//    -> The next full frame emits correctly with no stale samples.
// 6. N = 8, LOG2N = 3, frame 0..7
//    -> output 0, 4, 2, 6, 1, 5, 3, 7; out_idx matches the output value.

Source files
------------

// File: rtl/bitrev_frame_feeder.sv
// bitrev_frame_feeder
// Ping-pong frame buffer that accepts complex samples in natural order and
// emits each completed frame in bit-reversed order. One bank fills while
// the other drains, so the block sustains one sample per cycle.
// Valid/ready handshakes on both sides carry back-pressure.
module bitrev_frame_feeder #(
   parameter int N     = 64,
   parameter int LOG2N = 6,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_re,
   input  logic [WIDTH-1:0] in_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_re,
   output logic [WIDTH-1:0] out_im,
   output logic             out_sof,
   output logic             out_eof,
   output logic [LOG2N-1:0] out_idx
);

   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

   // Sample storage; contents are deliberately left unreset.
   logic [WIDTH-1:0] bank_re [0:1][0:N-1];
   logic [WIDTH-1:0] bank_im [0:1][0:N-1];

   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
   logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

   logic             wr_fire;
   logic             rd_fire;
   logic             rd_valid;
   logic [LOG2N-1:0] rd_addr;

   // Reverse the bit order of a frame index.
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = v[LOG2N-1-i];
      end
      return r;
   endfunction

   // in_ready is forced low while reset is asserted so every output reads 0.
   assign in_ready = reset_n & ~full_q[wr_bank_q];
   assign wr_fire  = in_valid & in_ready;

   assign rd_valid = full_q[rd_bank_q];
   assign rd_addr  = bitrev(rd_cnt_q);
   assign rd_fire  = rd_valid & out_ready;

   // Read port: combinational read of the draining bank, zeroed when idle.
   always_comb begin
      out_valid = rd_valid;
      out_re    = '0;
      out_im    = '0;
      out_idx   = '0;
      out_sof   = 1'b0;
      out_eof   = 1'b0;
      if (rd_valid) begin
         out_re  = bank_re[rd_bank_q][rd_addr];
         out_im  = bank_im[rd_bank_q][rd_addr];
         out_idx = rd_addr;
         out_sof = (rd_cnt_q == '0);
         out_eof = (rd_cnt_q == LAST);
      end
   end

   // Next-state for the write/read pointers and the per-bank full flags.
   // A set and a clear in one cycle always hit different banks, so both
   // updates are applied independently to full_d.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      if (wr_fire) begin
         if (wr_cnt_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_cnt_d          = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end
      if (rd_fire) begin
         if (rd_cnt_q == LAST) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end
   end

   // Control state; reset discards any partial or pending frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   // Store each accepted sample at its natural-order position.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         bank_re[wr_bank_q][wr_cnt_q] <= in_re;
         bank_im[wr_bank_q][wr_cnt_q] <= in_im;
      end
   end

endmodule

// File: tb/tb_bitrev_frame_feeder.sv
// Self-checking bench for bitrev_frame_feeder (N=64 instance plus an N=8
// instance). Expected output samples are queued when a frame is fully
// accepted and popped as the DUT consumes them.
module tb_bitrev_frame_feeder;

   localparam int N     = 64;
   localparam int LOG2N = 6;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] in_re, in_im, out_re, out_im;
   logic             out_sof, out_eof;
   logic [LOG2N-1:0] out_idx;

   logic             in_valid8, in_ready8, out_valid8, out_ready8;
   logic [WIDTH-1:0] in_re8, in_im8, out_re8, out_im8;
   logic             out_sof8, out_eof8;
   logic [2:0]       out_idx8;

   always #5 clk = ~clk;

   bitrev_frame_feeder #(.N(N), .LOG2N(LOG2N), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_sof(out_sof), .out_eof(out_eof), .out_idx(out_idx)
   );

   bitrev_frame_feeder #(.N(8), .LOG2N(3), .WIDTH(WIDTH)) dut8 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_re(in_re8), .in_im(in_im8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_re(out_re8), .out_im(out_im8),
      .out_sof(out_sof8), .out_eof(out_eof8), .out_idx(out_idx8)
   );

   typedef struct {
      logic [WIDTH-1:0] re;
      logic [WIDTH-1:0] im;
      logic [LOG2N-1:0] idx;
      logic             sof;
      logic             eof;
   } exp_t;

   exp_t q[$];

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] fr_re [N];
   logic [WIDTH-1:0] fr_im [N];
   int in_k, frames_left, pv, pr, data_mode;
   int cyc, n_acc, n_cons, first_cons_cyc, last_cons_cyc, ir_low_cnt;
   logic s_in_ready, prev_stall;
   logic [WIDTH-1:0] cons_log [4];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_bitrev(input int v, input int bits);
      int r = 0;
      for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

   task automatic gen_frame();
      for (int k = 0; k < N; k++) begin
         if (data_mode == 0) begin
            fr_re[k] = WIDTH'(k);
            fr_im[k] = WIDTH'(1000 + k);
         end else begin
            fr_re[k] = $urandom;
            fr_im[k] = $urandom;
         end
      end
   endtask

   task automatic push_frame();
      exp_t e;
      for (int j = 0; j < N; j++) begin
         e.idx = LOG2N'(ref_bitrev(j, LOG2N));
         e.re  = fr_re[e.idx];
         e.im  = fr_im[e.idx];
         e.sof = (j == 0);
         e.eof = (j == N - 1);
         q.push_back(e);
      end
   endtask

   task automatic reset_counters();
      n_acc = 0; n_cons = 0; ir_low_cnt = 0;
      first_cons_cyc = -1; last_cons_cyc = -1;
   endtask

   // One clock cycle: observe at negedge, advance stimulus just after posedge.
   task automatic step();
      logic acc, cons;
      int   fullcnt;
      @(negedge clk);
      cyc++;
      s_in_ready = in_ready;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (!in_ready) ir_low_cnt++;
      fullcnt = (q.size() + N - 1) / N;
      check_val("out_valid", out_valid, q.size() != 0);
      check_val("in_ready", in_ready, fullcnt < 2);
      if (prev_stall) check_val("stall_hold_valid", out_valid, 1);
      if (out_valid && q.size() != 0) begin
         check_val("out_re", out_re, q[0].re);
         check_val("out_im", out_im, q[0].im);
         check_val("out_idx", out_idx, q[0].idx);
         check_val("out_sof", out_sof, q[0].sof);
         check_val("out_eof", out_eof, q[0].eof);
         if (cons) begin
            void'(q.pop_front());
            if (n_cons < 4) cons_log[n_cons] = out_re;
            if (first_cons_cyc < 0) first_cons_cyc = cyc;
            last_cons_cyc = cyc;
            n_cons++;
         end
      end else if (!out_valid) begin
         check_val("idle_outputs_zero", {out_re, out_im, out_idx, out_sof, out_eof}, 0);
      end
      prev_stall = out_valid && !out_ready;
      if (acc) n_acc++;
      @(posedge clk);
      #1;
      if (acc) begin
         if (in_k == N - 1) begin
            push_frame();
            frames_left--;
            in_k = 0;
            gen_frame();
         end else begin
            in_k++;
         end
      end
      in_valid  = (frames_left > 0) && (($urandom % 100) < pv);
      in_re     = fr_re[in_k];
      in_im     = fr_im[in_k];
      out_ready = ($urandom % 100) < pr;
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int c = 0;
      while ((frames_left > 0 || in_k != 0 || q.size() != 0) && c < max_cyc) begin
         step();
         c++;
      end
      check_val({tag, "_drain"}, frames_left + in_k + q.size(), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int exp4 [4];
      int exp8 [8];
      int j8, k8;
      logic acc8;

      reset_n = 1'b0;
      in_valid = 0; in_re = '0; in_im = '0; out_ready = 0;
      in_valid8 = 0; in_re8 = '0; in_im8 = '0; out_ready8 = 1;
      in_k = 0; frames_left = 0; pv = 0; pr = 0; data_mode = 0;
      cyc = 0; prev_stall = 0; s_in_ready = 0;
      reset_counters();
      gen_frame();

      // Reset state
      #1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_in_ready_low", in_ready, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_val("rst_in_ready_high", in_ready, 1);
      check_val("rst_outputs_zero", {out_valid, out_re, out_im, out_idx, out_sof, out_eof}, 0);

      // Test 1: single ramp frame, out_ready high
      data_mode = 0; gen_frame();
      frames_left = 1; pv = 100; pr = 100;
      reset_counters();
      c = 0;
      while (frames_left > 0 && c < 500) begin step(); c++; end
      check_val("t1_frame_accepted", frames_left, 0);
      check_val("t1_latency", out_valid, 1);
      drain("t1", 500);
      exp4 = '{0, 32, 16, 48};
      for (int i = 0; i < 4; i++) check_val("t1_first_order", cons_log[i], exp4[i]);
      check_val("t1_consumed", n_cons, 64);

      // Test 2: three back-to-back frames, no stalls
      data_mode = 1; gen_frame();
      frames_left = 3; pv = 100; pr = 100;
      reset_counters();
      drain("t2", 1000);
      check_val("t2_in_ready_never_low", ir_low_cnt, 0);
      check_val("t2_consumed", n_cons, 192);
      check_val("t2_gap_free", last_cons_cyc - first_cons_cyc, 191);

      // Test 3: output blocked, both banks fill
      frames_left = 3; pv = 100; pr = 0;
      reset_counters();
      repeat (200) step();
      check_val("t3_accepts_before_full", n_acc, 128);
      check_val("t3_in_ready_low", in_ready, 0);
      pr = 100;
      c = 0;
      while (n_cons < 64 && c < 300) begin step(); c++; end
      check_val("t3_ready_low_at_last_consume", s_in_ready, 0);
      check_val("t3_ready_back_next_cycle", in_ready, 1);
      drain("t3", 1000);

      // Test 4: random gaps and back-pressure over 20 frames
      frames_left = 20; pv = 70; pr = 60;
      reset_counters();
      drain("t4", 10000);
      check_val("t4_consumed", n_cons, 20 * N);

      // Test 5: reset mid-frame with a full frame pending
      frames_left = 2; pv = 100; pr = 0;
      reset_counters();
      c = 0;
      while (n_acc < N + 20 && c < 400) begin step(); c++; end
      check_val("t5_accepts", n_acc, N + 20);
      check_val("t5_pending_valid", out_valid, 1);
      #2;
      reset_n = 1'b0;
      in_valid = 0;
      #1;
      check_val("t5_rst_outputs_zero",
                {out_valid, in_ready, out_re, out_im, out_idx, out_sof, out_eof}, 0);
      q.delete();
      in_k = 0; frames_left = 0; prev_stall = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_val("t5_after_rst_ready", in_ready, 1);
      check_val("t5_after_rst_valid", out_valid, 0);
      gen_frame();
      frames_left = 1; pv = 100; pr = 100;
      reset_counters();
      drain("t5", 500);
      check_val("t5_consumed", n_cons, N);

      // Test 6: N=8 instance, ramp 0..7
      exp8 = '{0, 4, 2, 6, 1, 5, 3, 7};
      @(posedge clk);
      #1;
      k8 = 0; j8 = 0;
      in_valid8 = 1; in_re8 = 0; in_im8 = 100; out_ready8 = 1;
      c = 0;
      while (j8 < 8 && c < 60) begin
         @(negedge clk);
         acc8 = in_valid8 && in_ready8;
         if (out_valid8 && out_ready8) begin
            check_val("t6_re", out_re8, exp8[j8]);
            check_val("t6_im", out_im8, 100 + exp8[j8]);
            check_val("t6_idx", out_idx8, exp8[j8]);
            check_val("t6_sof", out_sof8, j8 == 0);
            check_val("t6_eof", out_eof8, j8 == 7);
            j8++;
         end
         @(posedge clk);
         #1;
         if (acc8) begin
            k8++;
            if (k8 == 8) in_valid8 = 0;
            in_re8 = WIDTH'(k8);
            in_im8 = WIDTH'(100 + k8);
         end
         c++;
      end
      check_val("t6_count", j8, 8);
      @(negedge clk);
      check_val("t6_idle", out_valid8, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
